m_axi_lite_dma_sched: RTL and testbench

Transaction scheduler in front of the `m_axi_lite_dma` AXI-lite master. It arbitrates up to `NUM_REQ` requesters round-robin and loads the winner's base address and word count into the DMA master. It pulses `INIT_AXI_TXN`, waits for `TXN_DONE` under a watchdog, and returns a per-requester completion pulse with status. Sits between the control plane and the single DMA master instance.

---
 rtl/m_axi_lite_dma_sched.sv | 186 ++++++++++++++++++
 tb/tb_m_axi_lite_dma_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_lite_dma_sched.sv
// m_axi_lite_dma_sched
// Round-robin transaction scheduler in front of a single AXI-lite DMA master.
// Picks one requester at a time, hands its base address / word count to the
// DMA master, fires a one-cycle start pulse, waits for completion under a
// watchdog and returns a one-hot completion pulse with a 2-bit status.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   REQ_VALID[N]        per-requester request level
//   REQ_ADDR, REQ_LEN   packed per-requester base address / word count
//   REQ_GRANT[N]        one-hot pulse: request accepted
//   REQ_DONE[N]         one-hot pulse: request finished, REQ_STATUS valid
//   REQ_STATUS[2]       00 ok, 01 AXI error, 10 timeout, 11 zero length
//   DMA_BASE_ADDR/LEN   transfer parameters held until the next grant
//   DMA_INIT_AXI_TXN    one-cycle start pulse to the DMA master
//   DMA_TXN_DONE/ERROR  completion level / error flag from the DMA master
//   BUSY                high whenever the scheduler is not idle
module m_axi_lite_dma_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  REQ_LEN,
  output logic [NUM_REQ-1:0]            REQ_GRANT,
  output logic [NUM_REQ-1:0]            REQ_DONE,
  output logic [1:0]                    REQ_STATUS,
  output logic [ADDR_WIDTH-1:0]         DMA_BASE_ADDR,
  output logic [LEN_WIDTH-1:0]          DMA_LEN,
  output logic                          DMA_INIT_AXI_TXN,
  input  logic                          DMA_TXN_DONE,
  input  logic                          DMA_ERROR,
  output logic                          BUSY
);

  localparam int          IDX_W  = $clog2(NUM_REQ);
  localparam int          TMR_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned NREQ_U = NUM_REQ;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_AXI_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ZERO    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [1:0]            status_q, status_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  init_q, init_d;
  logic                  busy_q, busy_d;

  logic [IDX_W-1:0]      pick;
  logic                  pick_found;
  logic [LEN_WIDTH-1:0]  pick_len;

  // Round-robin search: first requester at or after ptr+1, wrapping.
  always_comb begin
    int unsigned idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      idx = (32'(ptr_q) + k) % NREQ_U;
      if (!pick_found && REQ_VALID[idx[IDX_W-1:0]]) begin
        pick       = idx[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
    pick_len = REQ_LEN[pick*LEN_WIDTH +: LEN_WIDTH];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      sel_q    <= '0;
      timer_q  <= '0;
      status_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      init_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    status_d = status_q;
    addr_d   = addr_q;
    len_d    = len_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d  = pick;
          addr_d = REQ_ADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
          len_d  = pick_len;
          if (pick_len == '0) begin
            status_d = ST_ZERO;
            state_d  = S_REPORT;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The timer holds at zero while the registered start pulse is still
        // on the wire, so it counts cycles after the DMA master saw it.
        if (!init_q && timer_q != TMR_LAST) begin
          timer_d = timer_q + 1'b1;
        end
        // Done is blanked for timer < 2 to reject the previous transfer's
        // level; it takes priority over a simultaneous timeout.
        if (timer_q >= TMR_W'(2) && DMA_TXN_DONE) begin
          status_d = DMA_ERROR ? ST_AXI_ERR : ST_OK;
          state_d  = S_REPORT;
        end else if (timer_q == TMR_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_REPORT;
        end
      end
      S_REPORT: begin
        ptr_d   = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    done_d  = '0;
    init_d  = (state_q == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
    if (state_q == S_IDLE && state_d != S_IDLE) begin
      grant_d[sel_d] = 1'b1;
    end
    // WAIT completions surface as the FSM enters REPORT; zero-length
    // requests skip WAIT and surface one cycle later, from REPORT itself.
    if ((state_q == S_WAIT && state_d == S_REPORT) ||
        (state_q == S_REPORT && status_q == ST_ZERO)) begin
      done_d[sel_q] = 1'b1;
    end
  end

  assign REQ_GRANT        = grant_q;
  assign REQ_DONE         = done_q;
  assign REQ_STATUS       = status_q;
  assign DMA_BASE_ADDR    = addr_q;
  assign DMA_LEN          = len_q;
  assign DMA_INIT_AXI_TXN = init_q;
  assign BUSY             = busy_q;

endmodule

// File: tb/tb_m_axi_lite_dma_sched.sv
// Scoreboard bench for m_axi_lite_dma_sched: stimulus pushes expected grant /
// done events, a negedge monitor pops and compares them, a small DMA model
// answers start pulses with configurable stale-done, latency and error.
module tb_m_axi_lite_dma_sched;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int LW    = 8;
  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic            ACLK   = 1'b0;
  logic            ARESET = 1'b1;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N*AW-1:0] REQ_ADDR  = '0;
  logic [N*LW-1:0] REQ_LEN   = '0;
  logic [N-1:0]    REQ_GRANT;
  logic [N-1:0]    REQ_DONE;
  logic [1:0]      REQ_STATUS;
  logic [AW-1:0]   DMA_BASE_ADDR;
  logic [LW-1:0]   DMA_LEN;
  logic            DMA_INIT_AXI_TXN;
  logic            DMA_TXN_DONE = 1'b1;
  logic            DMA_ERROR    = 1'b0;
  logic            BUSY;

  m_axi_lite_dma_sched #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(T)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .REQ_GRANT(REQ_GRANT), .REQ_DONE(REQ_DONE), .REQ_STATUS(REQ_STATUS),
    .DMA_BASE_ADDR(DMA_BASE_ADDR), .DMA_LEN(DMA_LEN),
    .DMA_INIT_AXI_TXN(DMA_INIT_AXI_TXN), .DMA_TXN_DONE(DMA_TXN_DONE),
    .DMA_ERROR(DMA_ERROR), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [N-1:0]  onehot;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [1:0]    status;
    int            done_off;
    int            has_init;
  } exp_t;

  typedef struct {
    int   stale;
    int   r;
    logic err;
  } dma_t;

  exp_t exp_q[$];
  dma_t dma_q[$];

  int tests = 0, fails = 0, cyc = 0, dones_seen = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: per-requester transaction setup and round-robin pointer.
  int            ptr_m = N - 1;
  logic [AW-1:0] addr_v[N];
  logic [LW-1:0] len_v[N];
  int            stale_v[N];
  int            r_v[N];
  logic          err_v[N];

  // r = cycles from the start pulse to the DMA raising done (NEVER = no done).
  // Completion is reported r+2 cycles after the grant; a done at r <= T is
  // accepted (done beats timeout at r == T), otherwise timeout at T+2.
  function automatic void expect_txn(input int i);
    exp_t e;
    dma_t d;
    e.onehot = '0;
    e.onehot[i] = 1'b1;
    e.addr = addr_v[i];
    e.len  = len_v[i];
    if (len_v[i] == 0) begin
      e.status = 2'b11; e.done_off = 1; e.has_init = 0;
    end else begin
      e.has_init = 1;
      if (r_v[i] <= T) begin
        e.status = err_v[i] ? 2'b01 : 2'b00; e.done_off = 2 + r_v[i];
      end else begin
        e.status = 2'b10; e.done_off = 2 + T;
      end
      d.stale = stale_v[i]; d.r = r_v[i]; d.err = err_v[i];
      dma_q.push_back(d);
    end
    exp_q.push_back(e);
  endfunction

  function automatic void set_slot(input int i, input logic [AW-1:0] a,
                                   input logic [LW-1:0] l, input int s,
                                   input int r, input logic e);
    addr_v[i] = a; len_v[i] = l; stale_v[i] = s; r_v[i] = r; err_v[i] = e;
  endfunction

  function automatic void rand_slot(input int i);
    int sel;
    addr_v[i]  = $urandom;
    len_v[i]   = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 255));
    stale_v[i] = $urandom_range(0, 2);
    err_v[i]   = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 4);
    case (sel)
      0:       r_v[i] = 3;
      1:       r_v[i] = T;
      2:       r_v[i] = T + 1;
      3:       r_v[i] = NEVER;
      default: r_v[i] = $urandom_range(3, T);
    endcase
  endfunction

  // All requesters in mask assert together and hold until granted, so they
  // are served in cyclic order starting after the model pointer.
  task automatic run_round(input logic [N-1:0] mask);
    int target, budget, last;
    target = dones_seen;
    last = ptr_m;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (mask[i]) begin
        expect_txn(i);
        target++;
        last = i;
      end
    end
    ptr_m = last;
    @(negedge ACLK);
    for (int i = 0; i < N; i++) begin
      REQ_ADDR[i*AW +: AW] = addr_v[i];
      REQ_LEN[i*LW +: LW]  = len_v[i];
    end
    REQ_VALID = mask;
    budget = N * (T + 12) + 20;
    while (dones_seen < target && budget > 0) begin
      @(negedge ACLK);
      budget--;
      for (int i = 0; i < N; i++) begin
        if (REQ_GRANT[i]) begin
          REQ_VALID[i] = 1'b0;
          REQ_ADDR[i*AW +: AW] = $urandom;
          REQ_LEN[i*LW +: LW]  = LW'($urandom);
        end
      end
    end
    if (dones_seen < target) chk("round_complete", 64'(dones_seen), 64'(target));
    REQ_VALID = '0;
  endtask

  // DMA master model.
  dma_t dc;
  initial begin
    forever begin
      @(negedge ACLK);
      if (DMA_INIT_AXI_TXN && !ARESET) begin
        if (dma_q.size() == 0) begin
          chk("dma_unexpected_start", 64'(DMA_INIT_AXI_TXN), 64'd0);
        end else begin
          dc = dma_q.pop_front();
          repeat (dc.stale) @(negedge ACLK);
          DMA_TXN_DONE = 1'b0;
          DMA_ERROR    = 1'b0;
          if (dc.r != NEVER) begin
            repeat (dc.r - dc.stale) @(negedge ACLK);
            DMA_TXN_DONE = 1'b1;
            DMA_ERROR    = dc.err;
          end
        end
      end
    end
  end

  // Monitor.
  exp_t cur;
  bit   cur_valid = 1'b0;
  int   grant_cyc = 0, init_cnt = 0, busy_chk_cyc = -1;

  always @(negedge ACLK) begin
    if (ARESET) begin
      cur_valid    = 1'b0;
      busy_chk_cyc = -1;
    end else begin
      if (|REQ_GRANT) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 64'(REQ_GRANT), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          grant_cyc = cyc;
          init_cnt  = 0;
          chk("grant_onehot", 64'(REQ_GRANT), 64'(cur.onehot));
          chk("dma_base_addr", 64'(DMA_BASE_ADDR), 64'(cur.addr));
          chk("dma_len", 64'(DMA_LEN), 64'(cur.len));
          chk("busy_at_grant", 64'(BUSY), 64'd1);
        end
      end
      if (DMA_INIT_AXI_TXN) begin
        init_cnt++;
        if (!cur_valid) chk("unexpected_init", 64'(DMA_INIT_AXI_TXN), 64'd0);
        else            chk("init_cycle", 64'(cyc - grant_cyc), 64'd1);
      end
      if (busy_chk_cyc == cyc) chk("busy_after_done", 64'(BUSY), 64'd0);
      if (|REQ_DONE) begin
        if (!cur_valid) begin
          chk("unexpected_done", 64'(REQ_DONE), 64'd0);
        end else begin
          chk("done_onehot", 64'(REQ_DONE), 64'(cur.onehot));
          chk("done_status", 64'(REQ_STATUS), 64'(cur.status));
          chk("done_cycle", 64'(cyc - grant_cyc), 64'(cur.done_off));
          chk("init_count", 64'(init_cnt), 64'(cur.has_init));
          if (cur.has_init != 0) busy_chk_cyc = cyc + 1;
          else chk("busy_zero_len", 64'(BUSY), 64'd0);
          cur_valid = 1'b0;
          dones_seen++;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_grant"}, 64'(REQ_GRANT), 64'd0);
    chk({tag, "_done"}, 64'(REQ_DONE), 64'd0);
    chk({tag, "_status"}, 64'(REQ_STATUS), 64'd0);
    chk({tag, "_base"}, 64'(DMA_BASE_ADDR), 64'd0);
    chk({tag, "_len"}, 64'(DMA_LEN), 64'd0);
    chk({tag, "_init"}, 64'(DMA_INIT_AXI_TXN), 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge ACLK);
    check_outputs_zero("reset");
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // Single request.
    set_slot(0, 32'h4000_0000, 8'd4, 0, 10, 1'b0);
    run_round(4'b0001);

    // Round robin: 1,2 then 1 then 3,0.
    set_slot(1, 32'h1111_0000, 8'd7, 1, 5, 1'b0);
    set_slot(2, 32'h2222_0000, 8'd9, 2, 4, 1'b0);
    run_round(4'b0110);
    set_slot(1, 32'h1111_1000, 8'd3, 0, 6, 1'b0);
    run_round(4'b0010);
    set_slot(0, 32'h0000_0abc, 8'd1, 1, 8, 1'b0);
    set_slot(3, 32'h3333_0000, 8'd2, 2, 3, 1'b0);
    run_round(4'b1001);

    // Stale done ignored, error reported (new done at timer 6).
    set_slot(1, 32'h5555_0000, 8'd12, 2, 7, 1'b1);
    run_round(4'b0010);

    // Watchdog timeout.
    set_slot(2, 32'h6666_0000, 8'd9, 1, NEVER, 1'b0);
    run_round(4'b0100);

    // Zero length.
    set_slot(3, 32'h7777_0000, 8'd0, 0, 5, 1'b0);
    run_round(4'b1000);

    // Earliest accepted done, done/timeout tie, one past the tie.
    set_slot(0, 32'h8888_0000, 8'd5, 2, 3, 1'b0);
    run_round(4'b0001);
    set_slot(1, 32'h9999_0000, 8'd5, 0, T, 1'b1);
    run_round(4'b0010);
    set_slot(2, 32'haaaa_0000, 8'd5, 1, T + 1, 1'b0);
    run_round(4'b0100);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) rand_slot(i);
      run_round(N'($urandom_range(1, 15)));
    end

    // Reset during WAIT at timer 3.
    set_slot(2, 32'hdead_0000, 8'd5, 0, NEVER, 1'b0);
    expect_txn(2);
    @(negedge ACLK);
    REQ_ADDR[2*AW +: AW] = addr_v[2];
    REQ_LEN[2*LW +: LW]  = len_v[2];
    REQ_VALID = 4'b0100;
    budget = 20;
    while (REQ_GRANT == '0 && budget > 0) begin
      @(negedge ACLK);
      budget--;
    end
    if (REQ_GRANT == '0) chk("abort_grant", 64'(REQ_GRANT), 64'h4);
    REQ_VALID = '0;
    repeat (5) @(posedge ACLK);
    #2 ARESET = 1'b1;
    #1 check_outputs_zero("abort");
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    ptr_m = N - 1;
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < N; i++) begin
      rand_slot(i);
      if (r_v[i] > T) r_v[i] = 5;
    end
    run_round(4'b1111);

    repeat (4) @(negedge ACLK);
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
